// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and redirect sequencer for the 3-stage F/D/X pipeline.
// Drives stalls, X flush, PC select, dmem watchdog and perf counters.
module pipeline_hazard_ctrl #(
   parameter int RA_W     = 5,
   parameter int WAIT_MAX = 15,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [RA_W-1:0]  rs1D,
   input  logic [RA_W-1:0]  rs2D,
   input  logic             use_rs1D,
   input  logic             use_rs2D,
   input  logic [RA_W-1:0]  rdX,
   input  logic             reg_writeX,
   input  logic             mem_readX,
   input  logic             br_takenX,
   input  logic             jalrX,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             stallF,
   output logic             stallD,
   output logic             stallX,
   output logic             flushX,
   output logic [1:0]       pc_sel,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int WC_W = $clog2(WAIT_MAX + 1);
   localparam logic [WC_W-1:0] WC_MAX = WC_W'(WAIT_MAX);
   localparam logic [WC_W-1:0] WC_ONE = WC_W'(1);

   localparam logic [1:0] PC_SEQ  = 2'b00;
   localparam logic [1:0] PC_BR   = 2'b01;
   localparam logic [1:0] PC_JALR = 2'b10;
   localparam logic [1:0] PC_RST  = 2'b11;

   localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      MEM_WAIT,
      HALT
   } state_t;

   state_t          state;
   state_t          stateNext;
   logic [WC_W-1:0] waitCtr;
   logic [WC_W-1:0] waitCtrNext;
   logic            timeoutNext;

   logic            rs1Hit;
   logic            rs2Hit;
   logic            loadUse;
   logic            memMiss;
   logic            selMiss;
   logic            selJalr;
   logic            selBr;
   logic            selLoadUse;
   logic            isRedirect;

   // Hazard detection, flattened into mutually exclusive RUN-state selects.
   always_comb begin
      rs1Hit     = use_rs1D & (rs1D == rdX);
      rs2Hit     = use_rs2D & (rs2D == rdX);
      loadUse    = mem_readX & reg_writeX & (rdX != '0)
                 & (rs1Hit | rs2Hit);
      memMiss    = dmem_req & ~dmem_ready;
      selMiss    = memMiss;
      selJalr    = ~memMiss & jalrX;
      selBr      = ~memMiss & ~jalrX & br_takenX;
      selLoadUse = ~memMiss & ~jalrX & ~br_takenX & loadUse;
   end

   // Next-state and hazard outputs from current state plus inputs.
   always_comb begin
      stateNext   = state;
      waitCtrNext = waitCtr;
      timeoutNext = mem_timeout;
      stallF      = 1'b0;
      stallD      = 1'b0;
      stallX      = 1'b0;
      flushX      = 1'b0;
      pc_sel      = PC_SEQ;

      unique case (state)
         BOOT: begin
            pc_sel    = PC_RST;
            flushX    = 1'b1;
            stateNext = RUN;
         end

         RUN: begin
            unique case (1'b1)
               selMiss: begin
                  stallF      = 1'b1;
                  stallD      = 1'b1;
                  stallX      = 1'b1;
                  stateNext   = MEM_WAIT;
                  waitCtrNext = WC_ONE;
               end
               selJalr: begin
                  pc_sel = PC_JALR;
                  flushX = 1'b1;
               end
               selBr: begin
                  pc_sel = PC_BR;
                  flushX = 1'b1;
               end
               selLoadUse: begin
                  stallF = 1'b1;
                  stallD = 1'b1;
                  flushX = 1'b1;
               end
               default: begin
                  pc_sel = PC_SEQ;
               end
            endcase
         end

         MEM_WAIT: begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallX = 1'b1;
            if (dmem_ready) begin
               stateNext = RUN;
            end else if (waitCtr == WC_MAX) begin
               stateNext   = HALT;
               timeoutNext = 1'b1;
            end else begin
               waitCtrNext = waitCtr + WC_ONE;
            end
         end

         HALT: begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallX = 1'b1;
         end

         default: begin
            stateNext = BOOT;
         end
      endcase
   end

   always_comb begin
      isRedirect = (pc_sel == PC_BR) | (pc_sel == PC_JALR);
   end

   // State, wait counter and sticky watchdog flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= BOOT;
         waitCtr     <= '0;
         mem_timeout <= 1'b0;
      end else begin
         state       <= stateNext;
         waitCtr     <= waitCtrNext;
         mem_timeout <= timeoutNext;
      end
   end

   // Saturating perf counters for stalled and redirected cycles.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stallD && stall_cnt != CNT_SAT) begin
            stall_cnt <= stall_cnt + CNT_ONE;
         end
         if (isRedirect && flush_cnt != CNT_SAT) begin
            flush_cnt <= flush_cnt + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: vector table plus scoreboard queue,
// with hand-built sequences for dmem waits, timeout and async reset.
module tb_pipeline_hazard_ctrl;

   localparam int RA_W     = 5;
   localparam int WAIT_MAX = 15;
   localparam int CNT_W    = 4;
   localparam int CNT_MAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic [RA_W-1:0]  rs1D, rs2D, rdX;
   logic             use_rs1D, use_rs2D;
   logic             reg_writeX, mem_readX;
   logic             br_takenX, jalrX;
   logic             dmem_req, dmem_ready;
   logic             stallF, stallD, stallX, flushX;
   logic [1:0]       pc_sel;
   logic             mem_timeout;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   pipeline_hazard_ctrl #(
      .RA_W     (RA_W),
      .WAIT_MAX (WAIT_MAX),
      .CNT_W    (CNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rs1D        (rs1D),
      .rs2D        (rs2D),
      .use_rs1D    (use_rs1D),
      .use_rs2D    (use_rs2D),
      .rdX         (rdX),
      .reg_writeX  (reg_writeX),
      .mem_readX   (mem_readX),
      .br_takenX   (br_takenX),
      .jalrX       (jalrX),
      .dmem_req    (dmem_req),
      .dmem_ready  (dmem_ready),
      .stallF      (stallF),
      .stallD      (stallD),
      .stallX      (stallX),
      .flushX      (flushX),
      .pc_sel      (pc_sel),
      .mem_timeout (mem_timeout),
      .stall_cnt   (stall_cnt),
      .flush_cnt   (flush_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [4:0] rs1, rs2, rd;
      logic       u1, u2, rw, mr, br, jr, req, rdy;
      logic       eF, eD, eX, eFl;
      logic [1:0] ePc;
      logic       eTo;
   } vec_t;

   vec_t sbq[$];
   vec_t tbl[$];
   int   errors = 0;
   int   checks = 0;
   int   expStall = 0;
   int   expFlush = 0;

   function automatic vec_t mk(
      input string nm,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
      input logic u1, input logic u2, input logic rw, input logic mr,
      input logic br, input logic jr, input logic req, input logic rdy,
      input logic eF, input logic eD, input logic eX, input logic eFl,
      input logic [1:0] ePc, input logic eTo);
      vec_t v;
      v.name = nm;
      v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
      v.u1 = u1; v.u2 = u2; v.rw = rw; v.mr = mr;
      v.br = br; v.jr = jr; v.req = req; v.rdy = rdy;
      v.eF = eF; v.eD = eD; v.eX = eX; v.eFl = eFl;
      v.ePc = ePc; v.eTo = eTo;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 'h%0h expected 'h%0h", nm, act, exp);
      end
   endtask

   function automatic int sat(input int x);
      return (x >= CNT_MAX) ? CNT_MAX : x + 1;
   endfunction

   // Drive one cycle, compare outputs mid-cycle, then counters after the edge.
   task automatic step(input vec_t v);
      vec_t e;
      logic [31:0] act;
      logic [31:0] exp;
      rs1D = v.rs1; rs2D = v.rs2; rdX = v.rd;
      use_rs1D = v.u1; use_rs2D = v.u2;
      reg_writeX = v.rw; mem_readX = v.mr;
      br_takenX = v.br; jalrX = v.jr;
      dmem_req = v.req; dmem_ready = v.rdy;
      sbq.push_back(v);
      @(negedge clk);
      e = sbq.pop_front();
      act = {25'd0, stallF, stallD, stallX, flushX, pc_sel, mem_timeout};
      exp = {25'd0, e.eF, e.eD, e.eX, e.eFl, e.ePc, e.eTo};
      chk({e.name, " outs"}, act, exp);
      @(posedge clk);
      #1;
      if (rst) begin
         if (e.eD) expStall = sat(expStall);
         if (e.ePc == 2'b01 || e.ePc == 2'b10) expFlush = sat(expFlush);
      end
      chk({e.name, " stall_cnt"}, 32'(stall_cnt), 32'(expStall));
      chk({e.name, " flush_cnt"}, 32'(flush_cnt), 32'(expFlush));
   endtask

   vec_t idle;

   initial begin
      idle = mk("idle", 0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0, 2'b00, 0);

      // name              rs1 rs2 rd  u1 u2 rw mr br jr rq rdy  F D X Fl pc  to
      tbl.push_back(mk("lu_rs1",    5, 0, 5, 1,0,1,1, 0,0,0,0, 1,1,0,1, 2'b00, 0));
      tbl.push_back(mk("lu_rs2",    3, 7, 7, 0,1,1,1, 0,0,0,0, 1,1,0,1, 2'b00, 0));
      tbl.push_back(mk("rd0_load",  0, 0, 0, 1,1,1,1, 0,0,0,0, 0,0,0,0, 2'b00, 0));
      tbl.push_back(mk("no_use",    5, 5, 5, 0,0,1,1, 0,0,0,0, 0,0,0,0, 2'b00, 0));
      tbl.push_back(mk("no_rw",     5, 0, 5, 1,0,0,1, 0,0,0,0, 0,0,0,0, 2'b00, 0));
      tbl.push_back(mk("alu_dep",   5, 0, 5, 1,0,1,0, 0,0,0,0, 0,0,0,0, 2'b00, 0));
      tbl.push_back(mk("mismatch",  4, 6, 5, 1,1,1,1, 0,0,0,0, 0,0,0,0, 2'b00, 0));
      tbl.push_back(mk("rs2_off",   5, 9, 5, 0,1,1,1, 0,0,0,0, 0,0,0,0, 2'b00, 0));
      tbl.push_back(mk("br",        0, 0, 0, 0,0,0,0, 1,0,0,0, 0,0,0,1, 2'b01, 0));
      tbl.push_back(mk("jalr",      0, 0, 0, 0,0,0,0, 0,1,0,0, 0,0,0,1, 2'b10, 0));
      tbl.push_back(mk("jalr_br",   0, 0, 0, 0,0,0,0, 1,1,0,0, 0,0,0,1, 2'b10, 0));
      tbl.push_back(mk("br_lu",     5, 0, 5, 1,0,1,1, 1,0,0,0, 0,0,0,1, 2'b01, 0));
      tbl.push_back(mk("jalr_lu",   5, 0, 5, 1,0,1,1, 0,1,0,0, 0,0,0,1, 2'b10, 0));
      tbl.push_back(mk("dmem_hit",  0, 0, 0, 0,0,0,0, 0,0,1,1, 0,0,0,0, 2'b00, 0));
      tbl.push_back(mk("hit_lu",    8, 0, 8, 1,0,1,1, 0,0,1,1, 1,1,0,1, 2'b00, 0));

      rst = 1'b0;
      rs1D = '0; rs2D = '0; rdX = '0;
      use_rs1D = 0; use_rs2D = 0; reg_writeX = 0; mem_readX = 0;
      br_takenX = 0; jalrX = 0; dmem_req = 0; dmem_ready = 0;
      repeat (2) @(posedge clk);
      #1;

      step(mk("in_reset", 0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,1, 2'b11, 0));
      rst = 1'b1;
      step(mk("boot", 0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,1, 2'b11, 0));
      step(idle);

      foreach (tbl[i]) step(tbl[i]);
      step(idle);

      // Three missing cycles then ready; the held jalr redirects only after exit.
      step(mk("miss_jalr", 0,0,0, 0,0,0,0, 0,1,1,0, 1,1,1,0, 2'b00, 0));
      repeat (2)
         step(mk("wait_jalr", 0,0,0, 0,0,0,0, 0,1,1,0, 1,1,1,0, 2'b00, 0));
      step(mk("wait_done", 0,0,0, 0,0,0,0, 0,1,1,1, 1,1,1,0, 2'b00, 0));
      step(mk("post_jalr", 0,0,0, 0,0,0,0, 0,1,0,0, 0,0,0,1, 2'b10, 0));
      step(idle);

      // Push flush_cnt into saturation.
      repeat (12)
         step(mk("br_sat", 0,0,0, 0,0,0,0, 1,0,0,0, 0,0,0,1, 2'b01, 0));

      // Sixteen cycles without ready trips the watchdog.
      repeat (WAIT_MAX + 1)
         step(mk("to_wait", 0,0,0, 0,0,0,0, 0,0,1,0, 1,1,1,0, 2'b00, 0));
      repeat (2)
         step(mk("halt", 0,0,0, 0,0,0,0, 1,1,1,1, 1,1,1,0, 2'b00, 1));

      // Asynchronous reset between edges clears everything at once.
      #2;
      rst = 1'b0;
      #1;
      chk("async_rst outs",
          {25'd0, stallF, stallD, stallX, flushX, pc_sel, mem_timeout},
          32'b0001_110);
      chk("async_rst stall_cnt", 32'(stall_cnt), 32'd0);
      chk("async_rst flush_cnt", 32'(flush_cnt), 32'd0);
      expStall = 0;
      expFlush = 0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      step(mk("reboot", 0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,1, 2'b11, 0));
      step(idle);
      step(mk("lu_again", 5, 0, 5, 1,0,1,1, 0,0,0,0, 1,1,0,1, 2'b00, 0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
